// File: rtl/uart_rx_service_ctrl_if.sv
// Bundle of receiver-side, configuration and consumer-side signals of the UART RX service sequencer.
// master is the sequencer's view; slave is the surrounding receiver/host view.
interface uart_rx_service_ctrl_if #(
   parameter int ERR_CNT_W = 8
);
   logic                 cfg_we;
   logic [4:0]           cfg_wdata;
   logic                 rx_enable;
   logic                 D_num;
   logic                 S_num;
   logic [1:0]           Par;
   logic                 Rx_RDY;
   logic                 PE_Fg;
   logic                 FE_Fg;
   logic                 OE_Fg;
   logic [7:0]           rx_data;
   logic                 n_RD;
   logic                 C_nD;
   logic                 Clr_EF;
   logic [7:0]           m_data;
   logic [2:0]           m_err;
   logic                 m_valid;
   logic                 m_ready;
   logic                 host_int_n;
   logic                 fifo_full;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (
      input  cfg_we, cfg_wdata, Rx_RDY, PE_Fg, FE_Fg, OE_Fg, rx_data, m_ready,
      output rx_enable, D_num, S_num, Par, n_RD, C_nD, Clr_EF,
             m_data, m_err, m_valid, host_int_n, fifo_full, err_cnt
   );

   modport slave (
      output cfg_we, cfg_wdata, Rx_RDY, PE_Fg, FE_Fg, OE_Fg, rx_data, m_ready,
      input  rx_enable, D_num, S_num, Par, n_RD, C_nD, Clr_EF,
             m_data, m_err, m_valid, host_int_n, fifo_full, err_cnt
   );
endinterface

// File: rtl/uart_rx_service_ctrl.sv
// Host-side sequencer for the UART receiver: owns its configuration, reads bytes on Rx_RDY,
// clears error flags and queues {flags,byte} in a small FIFO for a valid/ready consumer.
module uart_rx_service_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int RD_LAT     = 1,
   parameter int ERR_CNT_W  = 8
) (
   input logic                    CLK50MHZ,
   input logic                    rst,
   uart_rx_service_ctrl_if.master bus
);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      CLR_ERR = 3'd4,
      GAP     = 3'd5
   } state_t;

   state_t               state_r, state_s;
   logic [WCW-1:0]       wait_cnt_r;
   logic [2:0]           flags_r;
   logic [4:0]           cfg_r, pend_r;
   logic                 pend_v_r;
   logic [10:0]          mem_r [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_r, rd_ptr_r, next_rd_s;
   logic [CW-1:0]        count_r, count_s;
   logic                 push_s, pop_s;
   logic [10:0]          push_data_s, head_s;
   logic [7:0]           m_data_r;
   logic [2:0]           m_err_r;
   logic                 m_valid_r, host_int_n_r, fifo_full_r;
   logic                 n_rd_r, c_nd_r, clr_ef_r;
   logic [ERR_CNT_W-1:0] err_cnt_r;

   // Next-state decode; the WAIT exit compare is never reached when RD_LAT is 1
   always_comb begin
      state_s = state_r;
      push_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (cfg_r[4] && bus.Rx_RDY && !fifo_full_r) state_s = READ;
            else                                          state_s = IDLE;
         end
         READ: begin
            if (RD_LAT == 1) state_s = CAPTURE;
            else             state_s = WAIT;
         end
         WAIT: begin
            if (wait_cnt_r == WCW'(RD_LAT - 2)) state_s = CAPTURE;
            else                                state_s = WAIT;
         end
         CAPTURE: begin
            push_s = 1'b1;
            if (flags_r != 3'b000) state_s = CLR_ERR;
            else                   state_s = GAP;
         end
         CLR_ERR: state_s = GAP;
         GAP:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, read-latency counter, flag snapshot, strobes and error counter
   always_ff @(posedge CLK50MHZ or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         wait_cnt_r <= WCW'(0);
         flags_r    <= 3'b000;
         n_rd_r     <= 1'b1;
         c_nd_r     <= 1'b1;
         clr_ef_r   <= 1'b0;
         err_cnt_r  <= ERR_CNT_W'(0);
      end else begin
         state_r  <= state_s;
         n_rd_r   <= (state_s != READ);
         c_nd_r   <= !((state_s == READ) || (state_s == WAIT));
         clr_ef_r <= (state_s == CLR_ERR);
         if (state_r == READ) begin
            flags_r    <= {bus.PE_Fg, bus.FE_Fg, bus.OE_Fg};
            wait_cnt_r <= WCW'(0);
         end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + WCW'(1);
         end
         if ((state_r == CLR_ERR) && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
            err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
         end
      end
   end

   // Config writes land directly in IDLE; otherwise held until the FSM returns to IDLE
   always_ff @(posedge CLK50MHZ or negedge rst) begin
      if (!rst) begin
         cfg_r    <= 5'b01100;
         pend_r   <= 5'b00000;
         pend_v_r <= 1'b0;
      end else if (state_r == IDLE) begin
         if (bus.cfg_we) cfg_r <= bus.cfg_wdata;
      end else if (state_r == GAP) begin
         if (bus.cfg_we)    cfg_r <= bus.cfg_wdata;
         else if (pend_v_r) cfg_r <= pend_r;
         pend_v_r <= 1'b0;
      end else if (bus.cfg_we) begin
         pend_r   <= bus.cfg_wdata;
         pend_v_r <= 1'b1;
      end
   end

   // FIFO bookkeeping; the head is pre-computed so m_data/m_err can stay registered
   always_comb begin
      pop_s       = m_valid_r & bus.m_ready;
      push_data_s = {flags_r, bus.rx_data};
      if (pop_s) next_rd_s = rd_ptr_r + PW'(1);
      else       next_rd_s = rd_ptr_r;
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + CW'(1);
         2'b01:   count_s = count_r - CW'(1);
         default: count_s = count_r;
      endcase
      if (push_s && (wr_ptr_r == next_rd_s)) head_s = push_data_s;
      else                                   head_s = mem_r[next_rd_s];
   end

   // FIFO storage
   always_ff @(posedge CLK50MHZ) begin
      if (push_s) mem_r[wr_ptr_r] <= push_data_s;
   end

   // FIFO pointers and registered consumer-side outputs; head holds its value when empty
   always_ff @(posedge CLK50MHZ or negedge rst) begin
      if (!rst) begin
         wr_ptr_r     <= PW'(0);
         rd_ptr_r     <= PW'(0);
         count_r      <= CW'(0);
         m_data_r     <= 8'h00;
         m_err_r      <= 3'b000;
         m_valid_r    <= 1'b0;
         host_int_n_r <= 1'b1;
         fifo_full_r  <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         rd_ptr_r     <= next_rd_s;
         count_r      <= count_s;
         m_valid_r    <= (count_s != CW'(0));
         host_int_n_r <= (count_s == CW'(0));
         fifo_full_r  <= (count_s == CW'(FIFO_DEPTH));
         if (count_s != CW'(0)) {m_err_r, m_data_r} <= head_s;
      end
   end

   assign bus.rx_enable  = cfg_r[4];
   assign bus.D_num      = cfg_r[3];
   assign bus.S_num      = cfg_r[2];
   assign bus.Par        = cfg_r[1:0];
   assign bus.n_RD       = n_rd_r;
   assign bus.C_nD       = c_nd_r;
   assign bus.Clr_EF     = clr_ef_r;
   assign bus.m_data     = m_data_r;
   assign bus.m_err      = m_err_r;
   assign bus.m_valid    = m_valid_r;
   assign bus.host_int_n = host_int_n_r;
   assign bus.fifo_full  = fifo_full_r;
   assign bus.err_cnt    = err_cnt_r;
endmodule

// File: tb/tb_uart_rx_service_ctrl.sv
// Randomised bench for uart_rx_service_ctrl: a receiver stub feeds bytes, and a transaction-level
// model (what was read, when it must appear, what config is in force) is compared every cycle.
module tb_uart_rx_service_ctrl;
   localparam int DEPTH  = 4;
   localparam int RD_LAT = 2;

   typedef struct packed {
      logic [10:0] v;
      int          vis;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   uart_rx_service_ctrl_if #(.ERR_CNT_W(8)) bus ();

   uart_rx_service_ctrl #(.FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT), .ERR_CNT_W(8)) dut (
      .CLK50MHZ(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [10:0] rx_q [$];
   ent_t        exp_q [$];
   logic [10:0] pop_log [$];
   int          reads_total = 0;
   int          valid_cycles = 0;
   int          clr_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [4:0] w);
      bus.cfg_we    = 1'b1;
      bus.cfg_wdata = w;
      tick(1);
      bus.cfg_we    = 1'b0;
   endtask

   task automatic wait_read_start(input int budget);
      logic found;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.n_RD == 1'b0) begin
            found = 1'b1;
            break;
         end
         tick(1);
      end
      chk("read_start_timeout", {31'd0, found}, 32'd1);
   endtask

   // Receiver stub: a read strobe consumes the head byte and presents it on rx_data
   initial begin
      logic        rd;
      logic [10:0] tmp;
      bus.Rx_RDY  = 1'b0;
      bus.rx_data = 8'h00;
      {bus.PE_Fg, bus.FE_Fg, bus.OE_Fg} = 3'b000;
      forever begin
         @(negedge clk);
         rd = (bus.n_RD == 1'b0) && rst;
         @(posedge clk);
         #2;
         if (rd && rx_q.size() > 0) begin
            tmp = rx_q.pop_front();
            bus.rx_data = tmp[7:0];
         end
         bus.Rx_RDY = (rx_q.size() > 0);
         if (rx_q.size() > 0) {bus.PE_Fg, bus.FE_Fg, bus.OE_Fg} = rx_q[0][10:8];
         else                 {bus.PE_Fg, bus.FE_Fg, bus.OE_Fg} = 3'b000;
      end
   end

   // Transaction model and per-cycle comparison
   initial begin
      logic [4:0]  exp_cfg, pend, nxt_cfg;
      logic        pend_v, exp_v, flg;
      logic        prev_en, prev_rdy, prev_room, prev_free;
      logic [10:0] last_pop, head, ent;
      logic [7:0]  err_exp;
      int          busy_end, last_read, clr_due, err_due, cnt;
      forever begin
         @(negedge clk);
         if (!rst) begin
            exp_q.delete();
            exp_cfg = 5'b01100; pend = 5'b00000; pend_v = 1'b0;
            busy_end = -10; last_read = -100; clr_due = -10; err_due = -10;
            err_exp = 8'd0; last_pop = 11'd0;
            prev_en = 1'b0; prev_rdy = 1'b0; prev_room = 1'b0; prev_free = 1'b0;
         end else begin
            if (bus.n_RD == 1'b0) begin
               reads_total++;
               chk("read_legal", {28'd0, prev_en, prev_rdy, prev_room, prev_free}, 32'hF);
               ent = (rx_q.size() > 0) ? rx_q[0] : 11'd0;
               exp_q.push_back('{ent, cyc + RD_LAT + 1});
               last_read = cyc;
               flg = (ent[10:8] != 3'b000);
               busy_end = cyc + RD_LAT + 1 + (flg ? 1 : 0);
               if (flg) begin
                  clr_due = cyc + RD_LAT + 1;
                  err_due = cyc + RD_LAT + 2;
               end
            end
            if (cyc == err_due && err_exp != 8'hFF) err_exp = err_exp + 8'd1;
            cnt = 0;
            foreach (exp_q[i]) if (exp_q[i].vis <= cyc) cnt++;
            exp_v = (cnt > 0);
            head  = exp_v ? exp_q[0].v : last_pop;
            chk("m_valid", {31'd0, bus.m_valid}, {31'd0, exp_v});
            chk("host_int_n", {31'd0, bus.host_int_n}, {31'd0, !exp_v});
            chk("fifo_full", {31'd0, bus.fifo_full}, {31'd0, (cnt == DEPTH)});
            chk("head", {21'd0, bus.m_err, bus.m_data}, {21'd0, head});
            chk("c_nd", {31'd0, bus.C_nD},
                {31'd0, !((cyc >= last_read) && (cyc < last_read + RD_LAT))});
            chk("clr_ef", {31'd0, bus.Clr_EF}, {31'd0, (cyc == clr_due)});
            chk("err_cnt", {24'd0, bus.err_cnt}, {24'd0, err_exp});
            chk("cfg", {27'd0, bus.rx_enable, bus.D_num, bus.S_num, bus.Par}, {27'd0, exp_cfg});
            if (bus.m_valid) valid_cycles++;
            if (bus.Clr_EF) clr_count++;
            if (bus.m_valid && bus.m_ready) pop_log.push_back({bus.m_err, bus.m_data});
            if (exp_v && bus.m_ready) begin
               ent_t e;
               e = exp_q.pop_front();
               last_pop = e.v;
            end
            prev_en   = exp_cfg[4];
            prev_rdy  = bus.Rx_RDY;
            prev_room = (cnt < DEPTH);
            prev_free = (cyc > busy_end);
            nxt_cfg = exp_cfg;
            if (bus.cfg_we) begin
               if ((cyc >= last_read) && (cyc <= busy_end)) begin
                  pend = bus.cfg_wdata;
                  pend_v = 1'b1;
               end else begin
                  nxt_cfg = bus.cfg_wdata;
               end
            end
            if ((cyc == busy_end) && pend_v) begin
               nxt_cfg = pend;
               pend_v = 1'b0;
            end
            exp_cfg = nxt_cfg;
         end
      end
   end

   initial begin
      int base, offered, drained;
      logic [7:0] b;
      logic [2:0] f;
      bus.cfg_we = 1'b0; bus.cfg_wdata = 5'b00000; bus.m_ready = 1'b0;
      tick(3);
      chk("rst_n_rd", {31'd0, bus.n_RD}, 32'd1);
      chk("rst_cfg", {27'd0, bus.rx_enable, bus.D_num, bus.S_num, bus.Par}, 32'h0C);
      chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
      chk("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
      rst = 1'b1;
      tick(2);

      cfg(5'b11110);
      chk("t1_enable", {31'd0, bus.rx_enable}, 32'd1);
      chk("t1_par", {30'd0, bus.Par}, 32'd2);

      bus.m_ready = 1'b1;
      base = reads_total; valid_cycles = 0; clr_count = 0; pop_log.delete();
      rx_q.push_back({3'b000, 8'h55});
      tick(20);
      chk("t2_reads", reads_total - base, 32'd1);
      chk("t2_pop", (pop_log.size() > 0) ? {21'd0, pop_log[0]} : 32'hFFFF, 32'h055);
      chk("t2_valid_cycles", valid_cycles, 32'd1);
      chk("t2_clr", clr_count, 32'd0);

      pop_log.delete(); clr_count = 0;
      rx_q.push_back({3'b010, 8'hA3});
      tick(20);
      chk("t3_pop", (pop_log.size() > 0) ? {21'd0, pop_log[0]} : 32'hFFFF, 32'h2A3);
      chk("t3_clr", clr_count, 32'd1);
      chk("t3_err_cnt", {24'd0, bus.err_cnt}, 32'd1);

      bus.m_ready = 1'b0; base = reads_total; pop_log.delete();
      for (int i = 1; i <= 5; i++) rx_q.push_back({3'b000, 8'(i)});
      tick(40);
      chk("t4_full", {31'd0, bus.fifo_full}, 32'd1);
      chk("t4_reads_stalled", reads_total - base, 32'd4);
      bus.m_ready = 1'b1; tick(1); bus.m_ready = 1'b0;
      tick(20);
      chk("t4_reads_after_pop", reads_total - base, 32'd5);
      bus.m_ready = 1'b1;
      tick(20);
      for (int i = 0; i < 5; i++)
         chk("t4_order", (pop_log.size() > i) ? {21'd0, pop_log[i]} : 32'hFFFF, 32'(i + 1));

      base = reads_total; pop_log.delete();
      rx_q.push_back({3'b000, 8'h77}); rx_q.push_back({3'b000, 8'h88});
      rx_q.push_back({3'b000, 8'h99});
      wait_read_start(20);
      tick(1);
      cfg(5'b01110);
      tick(30);
      chk("t5_reads", reads_total - base, 32'd1);
      chk("t5_enable", {31'd0, bus.rx_enable}, 32'd0);
      chk("t5_rdy_pending", {31'd0, bus.Rx_RDY}, 32'd1);
      chk("t5_pop", (pop_log.size() > 0) ? {21'd0, pop_log[0]} : 32'hFFFF, 32'h077);

      cfg(5'b11110);
      wait_read_start(20);
      tick(1);
      #2 rst = 1'b0;
      #1;
      chk("t6_n_rd", {31'd0, bus.n_RD}, 32'd1);
      chk("t6_m_valid", {31'd0, bus.m_valid}, 32'd0);
      chk("t6_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
      rx_q.delete();
      tick(2);
      rst = 1'b1; valid_cycles = 0; base = reads_total;
      tick(20);
      chk("t6_no_push", valid_cycles, 32'd0);
      chk("t6_no_read", reads_total - base, 32'd0);

      cfg(5'b11101);
      offered = 0; base = reads_total;
      for (int i = 0; i < 400; i++) begin
         bus.m_ready = ($urandom_range(0, 3) != 0);
         if (($urandom_range(0, 3) == 0) && (rx_q.size() < 8)) begin
            b = 8'($urandom);
            f = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            rx_q.push_back({f, b});
            offered++;
         end
         if ($urandom_range(0, 39) == 0)
            cfg({($urandom_range(0, 3) != 0), 4'($urandom)});
         else
            tick(1);
      end
      cfg(5'b10100);
      bus.m_ready = 1'b1;
      drained = 0;
      for (int i = 0; i < 600; i++) begin
         if (rx_q.size() == 0 && exp_q.size() == 0 && bus.m_valid == 1'b0) begin
            drained = 1;
            break;
         end
         tick(1);
      end
      tick(10);
      chk("rand_drained", drained, 32'd1);
      chk("rand_all_read", reads_total - base, offered);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
